xif_issue_arbiter: RTL and testbench

- Shares one CV-X-IF coprocessor issue channel between N_REQ CPU-side issue requesters, e.g. multiple harts or cores in front of one coprocessor.
- Round-robin arbitration with a grant lock that holds while a granted transaction waits for issue_ready.
- Request payload is passed through combinationally; the coprocessor's issue response is routed back only to the granted requester.
- Sits between the CPU issue ports and the coprocessor issue port in the tb/rtl integration.

---
 rtl/xif_issue_arbiter_pkg.sv | 39 +++
 rtl/xif_issue_arbiter_rr_pick.sv | 40 ++++
 rtl/xif_issue_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_xif_issue_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xif_issue_arbiter_pkg.sv
// ============================================================================
// Module      : xif_issue_arb_pkg
// Description : Shared types and helpers for the CV-X-IF issue arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package xif_issue_arb_pkg;

  localparam int unsigned PKG_X_NUM_RS       = 2;
  localparam int unsigned PKG_X_RFR_WIDTH    = 32;
  localparam int unsigned PKG_X_ID_WIDTH     = 4;
  localparam int unsigned PKG_X_HARTID_WIDTH = 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  typedef enum logic [0:0] {
    IDLE   = ST_IDLE,
    LOCKED = ST_LOCKED
  } arb_state_e;

  typedef struct packed {
    logic [31:0]                                   instr;
    logic [PKG_X_HARTID_WIDTH-1:0]                 hartid;
    logic [PKG_X_ID_WIDTH-1:0]                     id;
    logic [PKG_X_NUM_RS*PKG_X_RFR_WIDTH-1:0]       rs;
    logic [PKG_X_NUM_RS-1:0]                       rs_valid;
  } issue_payload_t;

  // Wrap-around increment of a round-robin pointer over n requesters.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    if (ptr + 32'd1 >= n) return 32'd0;
    return ptr + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xif_issue_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin first-one finder starting at i_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import xif_issue_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] w_cand [N];

  for (genvar k = 0; k < N; k++) begin : g_cand
    assign w_cand[k] = IDX_W'((32'(i_ptr) + 32'(k)) % 32'(N));
  end

  // Walk from the farthest candidate back so the nearest one to i_ptr wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[w_cand[k]]) begin
        o_found = 1'b1;
        o_idx   = w_cand[k];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/xif_issue_arbiter.sv
// ============================================================================
// Module      : xif_issue_arbiter
// Description : Round-robin arbiter sharing one CV-X-IF issue channel between
//               N_REQ requesters, with grant lock until issue_ready.
//               Optional counters: define XIF_ISSUE_ARB_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xif_issue_arbiter
  import xif_issue_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int X_NUM_RS       = 2,
  parameter int X_RFR_WIDTH    = 32,
  parameter int X_ID_WIDTH     = 4,
  parameter int X_HARTID_WIDTH = 1,
  parameter int IDX_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [N_REQ-1:0]                      req_valid_i,
  output logic [N_REQ-1:0]                      req_ready_o,
  input  logic [N_REQ*32-1:0]                   req_instr_i,
  input  logic [N_REQ*X_HARTID_WIDTH-1:0]       req_hartid_i,
  input  logic [N_REQ*X_ID_WIDTH-1:0]           req_id_i,
  input  logic [N_REQ*X_NUM_RS*X_RFR_WIDTH-1:0] req_rs_i,
  input  logic [N_REQ*X_NUM_RS-1:0]             req_rs_valid_i,
  output logic [N_REQ-1:0]                      resp_accept_o,
  output logic [N_REQ-1:0]                      resp_writeback_o,
  output logic                                  issue_valid_o,
  input  logic                                  issue_ready_i,
  output logic [31:0]                           issue_instr_o,
  output logic [X_HARTID_WIDTH-1:0]             issue_hartid_o,
  output logic [X_ID_WIDTH-1:0]                 issue_id_o,
  output logic [X_NUM_RS*X_RFR_WIDTH-1:0]       issue_rs_o,
  output logic [X_NUM_RS-1:0]                   issue_rs_valid_o,
  input  logic                                  issue_accept_i,
  input  logic                                  issue_writeback_i,
  output logic [IDX_W-1:0]                      grant_idx_o
`ifdef XIF_ISSUE_ARB_PERF_CNT_EN
  ,
  input  logic                                  perf_clr_i,
  output logic [N_REQ*32-1:0]                   perf_issued_o,
  output logic [31:0]                           perf_stall_o
`endif
);

  localparam int RS_W = X_NUM_RS * X_RFR_WIDTH;

  arb_state_e       r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_grant_q;

  logic             w_found;
  logic [IDX_W-1:0] w_winner;
  logic [IDX_W-1:0] w_sel_raw;
  logic             w_valid_raw;
  logic             w_drive_raw;
  logic [IDX_W-1:0] w_sel;
  logic             w_valid;
  logic             w_drive;
  logic             w_hs;

  logic [31:0]               w_instr_arr  [N_REQ];
  logic [X_HARTID_WIDTH-1:0] w_hartid_arr [N_REQ];
  logic [X_ID_WIDTH-1:0]     w_id_arr     [N_REQ];
  logic [RS_W-1:0]           w_rs_arr     [N_REQ];
  logic [X_NUM_RS-1:0]       w_rsv_arr    [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_instr_arr[g]  = req_instr_i[g*32 +: 32];
    assign w_hartid_arr[g] = req_hartid_i[g*X_HARTID_WIDTH +: X_HARTID_WIDTH];
    assign w_id_arr[g]     = req_id_i[g*X_ID_WIDTH +: X_ID_WIDTH];
    assign w_rs_arr[g]     = req_rs_i[g*RS_W +: RS_W];
    assign w_rsv_arr[g]    = req_rs_valid_i[g*X_NUM_RS +: X_NUM_RS];
  end

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req   (req_valid_i),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_winner)
  );

  // While locked the payload stays routed even if valid drops, so late
  // rs_valid updates from the granted requester reach the coprocessor.
  always_comb begin
    w_sel_raw   = w_winner;
    w_valid_raw = w_found;
    w_drive_raw = w_found;
    if (r_state == LOCKED) begin
      w_sel_raw   = r_grant_q;
      w_valid_raw = req_valid_i[r_grant_q];
      w_drive_raw = 1'b1;
    end
  end

  // Reset is folded in combinationally so outputs are quiet while rst_ni is low.
  assign w_sel   = rst_ni ? w_sel_raw : '0;
  assign w_valid = rst_ni & w_valid_raw;
  assign w_drive = rst_ni & w_drive_raw;
  assign w_hs    = w_valid & issue_ready_i;

  assign issue_valid_o    = w_valid;
  assign grant_idx_o      = w_sel;
  assign issue_instr_o    = w_drive ? w_instr_arr[w_sel]  : '0;
  assign issue_hartid_o   = w_drive ? w_hartid_arr[w_sel] : '0;
  assign issue_id_o       = w_drive ? w_id_arr[w_sel]     : '0;
  assign issue_rs_o       = w_drive ? w_rs_arr[w_sel]     : '0;
  assign issue_rs_valid_o = w_drive ? w_rsv_arr[w_sel]    : '0;

  for (genvar g = 0; g < N_REQ; g++) begin : g_route
    logic w_is_g;
    assign w_is_g              = (w_sel == IDX_W'(g));
    assign req_ready_o[g]      = w_hs & w_is_g;
    assign resp_accept_o[g]    = w_hs & w_is_g & issue_accept_i;
    assign resp_writeback_o[g] = w_hs & w_is_g & issue_writeback_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_grant_q <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            if (issue_ready_i) begin
              r_rr_ptr <= IDX_W'(rr_next(32'(w_winner), unsigned'(N_REQ)));
            end else begin
              r_grant_q <= w_winner;
              r_state   <= LOCKED;
            end
          end
        end
        LOCKED: begin
          // A withdrawn request abandons the lock without moving the pointer.
          if (!req_valid_i[r_grant_q]) begin
            r_state <= IDLE;
          end else if (issue_ready_i) begin
            r_rr_ptr <= IDX_W'(rr_next(32'(r_grant_q), unsigned'(N_REQ)));
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_locked_valid_held: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (r_state == LOCKED) |-> req_valid_i[r_grant_q]
  );
`endif

`ifdef XIF_ISSUE_ARB_PERF_CNT_EN
  logic [31:0] r_perf_issued [N_REQ];
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < N_REQ; r++) r_perf_issued[r] <= '0;
      r_perf_stall <= '0;
    end else if (perf_clr_i) begin
      for (int r = 0; r < N_REQ; r++) r_perf_issued[r] <= '0;
      r_perf_stall <= '0;
    end else begin
      for (int r = 0; r < N_REQ; r++) begin
        if (req_ready_o[r] && (r_perf_issued[r] != 32'hFFFF_FFFF)) begin
          r_perf_issued[r] <= r_perf_issued[r] + 32'd1;
        end
      end
      if (w_valid && !issue_ready_i && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_perf
    assign perf_issued_o[g*32 +: 32] = r_perf_issued[g];
  end
  assign perf_stall_o = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xif_issue_arbiter.sv
// ============================================================================
// Module      : tb_xif_issue_arbiter
// Description : Directed self-checking bench for xif_issue_arbiter (N_REQ=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xif_issue_arbiter;

  localparam int N_REQ          = 2;
  localparam int X_NUM_RS       = 2;
  localparam int X_RFR_WIDTH    = 32;
  localparam int X_ID_WIDTH     = 4;
  localparam int X_HARTID_WIDTH = 1;
  localparam int IDX_W          = 1;
  localparam int RS_W           = X_NUM_RS * X_RFR_WIDTH;

  logic                            clk_i = 1'b0;
  logic                            rst_ni = 1'b0;
  logic [N_REQ-1:0]                req_valid_i = '0;
  logic [N_REQ-1:0]                req_ready_o;
  logic [N_REQ*32-1:0]             req_instr_i = '0;
  logic [N_REQ*X_HARTID_WIDTH-1:0] req_hartid_i = '0;
  logic [N_REQ*X_ID_WIDTH-1:0]     req_id_i = '0;
  logic [N_REQ*RS_W-1:0]           req_rs_i = '0;
  logic [N_REQ*X_NUM_RS-1:0]       req_rs_valid_i = '0;
  logic [N_REQ-1:0]                resp_accept_o;
  logic [N_REQ-1:0]                resp_writeback_o;
  logic                            issue_valid_o;
  logic                            issue_ready_i = 1'b0;
  logic [31:0]                     issue_instr_o;
  logic [X_HARTID_WIDTH-1:0]       issue_hartid_o;
  logic [X_ID_WIDTH-1:0]           issue_id_o;
  logic [RS_W-1:0]                 issue_rs_o;
  logic [X_NUM_RS-1:0]             issue_rs_valid_o;
  logic                            issue_accept_i = 1'b0;
  logic                            issue_writeback_i = 1'b0;
  logic [IDX_W-1:0]                grant_idx_o;
`ifdef XIF_ISSUE_ARB_PERF_CNT_EN
  logic                            perf_clr_i = 1'b0;
  logic [N_REQ*32-1:0]             perf_issued_o;
  logic [31:0]                     perf_stall_o;
`endif

  xif_issue_arbiter #(
    .N_REQ          (N_REQ),
    .X_NUM_RS       (X_NUM_RS),
    .X_RFR_WIDTH    (X_RFR_WIDTH),
    .X_ID_WIDTH     (X_ID_WIDTH),
    .X_HARTID_WIDTH (X_HARTID_WIDTH),
    .IDX_W          (IDX_W)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_instr_i       (req_instr_i),
    .req_hartid_i      (req_hartid_i),
    .req_id_i          (req_id_i),
    .req_rs_i          (req_rs_i),
    .req_rs_valid_i    (req_rs_valid_i),
    .resp_accept_o     (resp_accept_o),
    .resp_writeback_o  (resp_writeback_o),
    .issue_valid_o     (issue_valid_o),
    .issue_ready_i     (issue_ready_i),
    .issue_instr_o     (issue_instr_o),
    .issue_hartid_o    (issue_hartid_o),
    .issue_id_o        (issue_id_o),
    .issue_rs_o        (issue_rs_o),
    .issue_rs_valid_o  (issue_rs_valid_o),
    .issue_accept_i    (issue_accept_i),
    .issue_writeback_i (issue_writeback_i),
    .grant_idx_o       (grant_idx_o)
`ifdef XIF_ISSUE_ARB_PERF_CNT_EN
    ,
    .perf_clr_i        (perf_clr_i),
    .perf_issued_o     (perf_issued_o),
    .perf_stall_o      (perf_stall_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  logic [31:0]               instr_tab  [N_REQ] = '{32'h0000_302B, 32'h0000_402B};
  logic [X_HARTID_WIDTH-1:0] hartid_tab [N_REQ] = '{1'b0, 1'b1};
  logic [X_ID_WIDTH-1:0]     id_tab     [N_REQ] = '{4'h3, 4'h9};
  logic [RS_W-1:0]           rs_tab     [N_REQ] = '{64'hAAAA_0001_AAAA_0000, 64'hBBBB_0001_BBBB_0000};
  logic [X_NUM_RS-1:0]       rsv_tab    [N_REQ] = '{2'b01, 2'b11};

  typedef struct {
    string                     tag;
    logic                      valid;
    logic                      chk_g;
    logic [IDX_W-1:0]          grant;
    logic [N_REQ-1:0]          ready;
    logic [N_REQ-1:0]          acc;
    logic [N_REQ-1:0]          wb;
    logic [31:0]               instr;
    logic [X_HARTID_WIDTH-1:0] hartid;
    logic [X_ID_WIDTH-1:0]     id;
    logic [RS_W-1:0]           rs;
    logic [X_NUM_RS-1:0]       rsv;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic load_payload();
    for (int r = 0; r < N_REQ; r++) begin
      req_instr_i[r*32 +: 32]                             = instr_tab[r];
      req_hartid_i[r*X_HARTID_WIDTH +: X_HARTID_WIDTH]    = hartid_tab[r];
      req_id_i[r*X_ID_WIDTH +: X_ID_WIDTH]                = id_tab[r];
      req_rs_i[r*RS_W +: RS_W]                            = rs_tab[r];
      req_rs_valid_i[r*X_NUM_RS +: X_NUM_RS]              = rsv_tab[r];
    end
  endtask

  task automatic check_out();
    exp_t e;
    cmp("sb_depth", 64'(sb.size()), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      cmp({e.tag, ".valid"},  64'(issue_valid_o),    64'(e.valid));
      cmp({e.tag, ".ready"},  64'(req_ready_o),      64'(e.ready));
      cmp({e.tag, ".accept"}, 64'(resp_accept_o),    64'(e.acc));
      cmp({e.tag, ".wback"},  64'(resp_writeback_o), 64'(e.wb));
      cmp({e.tag, ".instr"},  64'(issue_instr_o),    64'(e.instr));
      cmp({e.tag, ".hartid"}, 64'(issue_hartid_o),   64'(e.hartid));
      cmp({e.tag, ".id"},     64'(issue_id_o),       64'(e.id));
      cmp({e.tag, ".rs"},     64'(issue_rs_o),       64'(e.rs));
      cmp({e.tag, ".rsv"},    64'(issue_rs_valid_o), 64'(e.rsv));
      if (e.chk_g) cmp({e.tag, ".grant"}, 64'(grant_idx_o), 64'(e.grant));
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then check at the falling edge.
  task automatic step(input string tag, input logic rst, input logic [N_REQ-1:0] v,
                      input logic rdy, input logic acc, input logic wb,
                      input logic ev, input logic cg, input logic [IDX_W-1:0] g,
                      input logic [N_REQ-1:0] er, input logic [N_REQ-1:0] eacc,
                      input logic [N_REQ-1:0] ewb);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_ni            = rst;
    req_valid_i       = v;
    issue_ready_i     = rdy;
    issue_accept_i    = acc;
    issue_writeback_i = wb;
    load_payload();
    e.tag    = tag;
    e.valid  = ev;
    e.chk_g  = cg;
    e.grant  = g;
    e.ready  = er;
    e.acc    = eacc;
    e.wb     = ewb;
    e.instr  = ev ? instr_tab[g]  : '0;
    e.hartid = ev ? hartid_tab[g] : '0;
    e.id     = ev ? id_tab[g]     : '0;
    e.rs     = ev ? rs_tab[g]     : '0;
    e.rsv    = ev ? rsv_tab[g]    : '0;
    sb.push_back(e);
    @(negedge clk_i);
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    load_payload();
    // Reset held with both requesters asking: nothing may leak out.
    step("reset", 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);

    for (int i = 0; i < 6; i++) begin
      step($sformatf("rot%0d", i), 1'b1, 2'b11, 1'b1, 1'b0, 1'b0,
           1'b1, 1'b1, IDX_W'(i % 2), 2'(1 << (i % 2)), 2'b00, 2'b00);
    end

    // Grant lock on requester 0 while the coprocessor stalls.
    step("lockA", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    step("lockB", 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    rsv_tab[0] = 2'b11;
    step("lockC", 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    step("lockD", 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00);
    step("lockE", 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00);

    step("respF", 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b10, 2'b10);
    step("respG", 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00);

    // Asynchronous reset while locked on requester 1.
    step("rstH",  1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    step("rstI",  1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00);

    for (int i = 0; i < 3; i++) begin
      step($sformatf("b2b%0d", i), 1'b1, 2'b01, 1'b1, 1'b0, 1'b0,
           1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00);
    end
    step("idle", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);

`ifdef XIF_ISSUE_ARB_PERF_CNT_EN
    perf_clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    perf_clr_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step($sformatf("pstall%0d", i), 1'b1, 2'b01, 1'b0, 1'b0, 1'b0,
           1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    end
    for (int i = 0; i < 5; i++) begin
      step($sformatf("pr0_%0d", i), 1'b1, 2'b01, 1'b1, 1'b0, 1'b0,
           1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00);
    end
    for (int i = 0; i < 3; i++) begin
      step($sformatf("pr1_%0d", i), 1'b1, 2'b10, 1'b1, 1'b0, 1'b0,
           1'b1, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00);
    end
    step("pidle", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    cmp("perf_issued0", 64'(perf_issued_o[31:0]),  64'd5);
    cmp("perf_issued1", 64'(perf_issued_o[63:32]), 64'd3);
    cmp("perf_stall",   64'(perf_stall_o),         64'd4);
    perf_clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    perf_clr_i = 1'b0;
    @(negedge clk_i);
    cmp("perf_clr_issued", 64'(perf_issued_o), 64'd0);
    cmp("perf_clr_stall",  64'(perf_stall_o),  64'd0);
`endif

    cmp("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
